// File: rtl/multadd_result_accum.sv
// Frame accumulator for multiply-add results: saturating sum, max and sat flag per frame,
// completed frames queued in a 2-entry valid/ready output FIFO.
module multadd_result_accum #(
  parameter int unsigned RES_W = 17,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 4
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  input  logic [RES_W-1:0] iRESULT,
  output logic             oREADY,
  input  logic [CNT_W-1:0] iLEN,
  input  logic             iCLR,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [ACC_W-1:0] oSUM,
  output logic [RES_W-1:0] oMAX,
  output logic             oSAT,
  output logic [CNT_W:0]   oCOUNT,
  output logic             oBUSY
);

  typedef enum logic [0:0] {StIdle, StAccum} stateT;

  typedef struct packed {
    logic [ACC_W-1:0] frmSum;
    logic [RES_W-1:0] frmMax;
    logic             frmSat;
  } frameT;

  localparam logic [CNT_W:0] LenOne = (CNT_W+1)'(1);

  stateT            stateQ;
  logic [ACC_W-1:0] accQ;
  logic [RES_W-1:0] maxQ;
  logic             satQ;
  logic [CNT_W:0]   cntQ;
  logic [CNT_W:0]   lenQ;

  logic [1:0]       occQ;
  frameT            headQ;
  frameT            tailQ;

  logic             accept;
  logic             pop;
  logic             push;
  frameT            pushFrame;
  logic [ACC_W:0]   sumFull;
  logic             clip;
  logic [ACC_W-1:0] accNext;
  logic [RES_W-1:0] maxNext;
  logic [CNT_W:0]   lenSel;
  logic [CNT_W:0]   cntInc;

  assign oREADY = !iRST && (occQ != 2'd2);
  assign oVALID = (occQ != 2'd0);
  assign accept = iVALID && oREADY;
  assign pop    = oVALID && iREADY;

  assign oSUM   = headQ.frmSum;
  assign oMAX   = headQ.frmMax;
  assign oSAT   = headQ.frmSat;
  assign oCOUNT = cntQ;
  assign oBUSY  = (stateQ == StAccum);

  // Both addends are below 2^ACC_W, so the carry bit alone flags overflow.
  assign sumFull = {1'b0, accQ} + (ACC_W+1)'(iRESULT);
  assign clip    = sumFull[ACC_W];
  assign accNext = clip ? {ACC_W{1'b1}} : sumFull[ACC_W-1:0];
  assign maxNext = (iRESULT > maxQ) ? iRESULT : maxQ;
  assign cntInc  = cntQ + LenOne;

  always_comb begin
    lenSel = {1'b0, iLEN};
    if (iLEN == '0) lenSel = {1'b1, {CNT_W{1'b0}}};
  end

  always_comb begin
    push      = 1'b0;
    pushFrame = '{frmSum: accNext, frmMax: maxNext, frmSat: satQ | clip};
    if (accept && !iCLR) begin
      if (stateQ == StIdle) begin
        if (lenSel == LenOne) begin
          push      = 1'b1;
          pushFrame = '{frmSum: ACC_W'(iRESULT), frmMax: iRESULT, frmSat: 1'b0};
        end
      end else if (cntInc == lenQ) begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateQ <= StIdle;
      accQ   <= '0;
      maxQ   <= '0;
      satQ   <= 1'b0;
      cntQ   <= '0;
      lenQ   <= '0;
    end else if (iCLR) begin
      stateQ <= StIdle;
      accQ   <= '0;
      maxQ   <= '0;
      satQ   <= 1'b0;
      cntQ   <= '0;
    end else if (accept) begin
      unique case (stateQ)
        StIdle: begin
          lenQ <= lenSel;
          if (lenSel != LenOne) begin
            accQ   <= ACC_W'(iRESULT);
            maxQ   <= iRESULT;
            satQ   <= 1'b0;
            cntQ   <= LenOne;
            stateQ <= StAccum;
          end
        end
        StAccum: begin
          if (cntInc == lenQ) begin
            accQ   <= '0;
            maxQ   <= '0;
            satQ   <= 1'b0;
            cntQ   <= '0;
            stateQ <= StIdle;
          end else begin
            accQ <= accNext;
            maxQ <= maxNext;
            satQ <= satQ | clip;
            cntQ <= cntInc;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  // Push only happens below full, so push+pop implies occupancy 1: new frame replaces head.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      occQ  <= 2'd0;
      headQ <= '0;
      tailQ <= '0;
    end else if (push && pop) begin
      headQ <= pushFrame;
    end else if (push) begin
      if (occQ == 2'd0) headQ <= pushFrame;
      else              tailQ <= pushFrame;
      occQ <= occQ + 2'd1;
    end else if (pop) begin
      if (occQ == 2'd2) headQ <= tailQ;
      occQ <= occQ - 2'd1;
    end
  end

endmodule

// File: tb/tb_multadd_result_accum.sv
// Directed bench for multadd_result_accum: default instance plus a narrow-accumulator,
// long-frame instance for the saturation case.
module tb_multadd_result_accum;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iVALID = 1'b0;
  logic [16:0] iRESULT = '0;
  logic        oREADY;
  logic [3:0]  iLEN = '0;
  logic        iCLR = 1'b0;
  logic        oVALID;
  logic        iREADY = 1'b1;
  logic [23:0] oSUM;
  logic [16:0] oMAX;
  logic        oSAT;
  logic [4:0]  oCOUNT;
  logic        oBUSY;

  logic        iVALID2 = 1'b0;
  logic [16:0] iRESULT2 = '0;
  logic        oREADY2;
  logic [7:0]  iLEN2 = 8'd130;
  logic        iCLR2 = 1'b0;
  logic        oVALID2;
  logic        iREADY2 = 1'b1;
  logic [19:0] oSUM2;
  logic [16:0] oMAX2;
  logic        oSAT2;
  logic [8:0]  oCOUNT2;
  logic        oBUSY2;

  int nTests = 0;
  int nFail  = 0;

  always #5 iCLK = ~iCLK;

  multadd_result_accum dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iRESULT(iRESULT), .oREADY(oREADY),
    .iLEN(iLEN), .iCLR(iCLR), .oVALID(oVALID), .iREADY(iREADY), .oSUM(oSUM),
    .oMAX(oMAX), .oSAT(oSAT), .oCOUNT(oCOUNT), .oBUSY(oBUSY)
  );

  multadd_result_accum #(.RES_W(17), .ACC_W(20), .CNT_W(8)) dut20 (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID2), .iRESULT(iRESULT2), .oREADY(oREADY2),
    .iLEN(iLEN2), .iCLR(iCLR2), .oVALID(oVALID2), .iREADY(iREADY2), .oSUM(oSUM2),
    .oMAX(oMAX2), .oSAT(oSAT2), .oCOUNT(oCOUNT2), .oBUSY(oBUSY2)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge iCLK);
    #1;
  endtask

  // Present one sample for exactly one clock edge.
  task automatic feed(input logic [16:0] d);
    iVALID  = 1'b1;
    iRESULT = d;
    stepClk();
    iVALID  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    stepClk();
    stepClk();
    checkEq("rst_ready", oREADY, 0);
    checkEq("rst_valid", oVALID, 0);
    checkEq("rst_sum", oSUM, 0);
    checkEq("rst_max", oMAX, 0);
    checkEq("rst_sat", oSAT, 0);
    checkEq("rst_count", oCOUNT, 0);
    checkEq("rst_busy", oBUSY, 0);
    iRST = 1'b0;
    #1;
    checkEq("post_rst_ready", oREADY, 1);

    // Basic frame of 4
    iLEN = 4'd4;
    iREADY = 1'b1;
    feed(17'd100); checkEq("f4_cnt1", oCOUNT, 1); checkEq("f4_busy", oBUSY, 1);
    feed(17'd200); checkEq("f4_cnt2", oCOUNT, 2);
    feed(17'd300); checkEq("f4_cnt3", oCOUNT, 3); checkEq("f4_novalid", oVALID, 0);
    feed(17'd400);
    checkEq("f4_cnt0", oCOUNT, 0);
    checkEq("f4_valid", oVALID, 1);
    checkEq("f4_sum", oSUM, 1000);
    checkEq("f4_max", oMAX, 400);
    checkEq("f4_sat", oSAT, 0);
    stepClk();
    checkEq("f4_popped", oVALID, 0);
    checkEq("f4_hold_sum", oSUM, 1000);

    // Full-length frames of max-value samples
    iLEN = 4'd0;
    for (int f = 0; f < 9; f++) begin
      for (int i = 0; i < 16; i++) begin
        feed(17'h1FFFF);
        if (f == 0 && i == 14) checkEq("f16_cnt15", oCOUNT, 15);
      end
      checkEq("f16_valid", oVALID, 1);
      checkEq("f16_sum", oSUM, 2097136);
      if (f == 0) begin
        checkEq("f16_max", oMAX, 131071);
        checkEq("f16_sat", oSAT, 0);
      end
    end
    stepClk();
    checkEq("f16_drained", oVALID, 0);

    // Narrow accumulator saturates over a 130-sample frame
    iRESULT2 = 17'h1FFFF;
    iVALID2 = 1'b1;
    repeat (129) @(posedge iCLK);
    #1;
    checkEq("s20_cnt129", oCOUNT2, 129);
    checkEq("s20_novalid", oVALID2, 0);
    stepClk();
    iVALID2 = 1'b0;
    checkEq("s20_valid", oVALID2, 1);
    checkEq("s20_sum", oSUM2, 1048575);
    checkEq("s20_sat", oSAT2, 1);
    checkEq("s20_max", oMAX2, 131071);

    // Backpressure: 5 and 6 buffered, 7 stalls
    iREADY = 1'b0;
    iLEN = 4'd1;
    feed(17'd5);
    checkEq("bp_valid5", oVALID, 1);
    checkEq("bp_sum5", oSUM, 5);
    checkEq("bp_ready1", oREADY, 1);
    feed(17'd6);
    checkEq("bp_full_ready", oREADY, 0);
    checkEq("bp_head_stable", oSUM, 5);
    iVALID = 1'b1;
    iRESULT = 17'd7;
    stepClk();
    checkEq("bp_stall_ready", oREADY, 0);
    checkEq("bp_stall_sum", oSUM, 5);
    iREADY = 1'b1;
    stepClk();
    checkEq("bp_sum6", oSUM, 6);
    checkEq("bp_ready_again", oREADY, 1);
    iREADY = 1'b0;
    stepClk();
    iVALID = 1'b0;
    checkEq("bp_7_taken_ready", oREADY, 0);
    checkEq("bp_sum6_hold", oSUM, 6);
    iREADY = 1'b1;
    stepClk();
    checkEq("bp_sum7", oSUM, 7);
    checkEq("bp_valid7", oVALID, 1);
    stepClk();
    checkEq("bp_empty", oVALID, 0);

    // Clear drops partial frame and the sample presented with it
    iLEN = 4'd3;
    feed(17'd10);
    feed(17'd20);
    iCLR = 1'b1;
    feed(17'd30);
    iCLR = 1'b0;
    checkEq("clr_busy", oBUSY, 0);
    checkEq("clr_count", oCOUNT, 0);
    checkEq("clr_novalid", oVALID, 0);
    stepClk();
    checkEq("clr_still_empty", oVALID, 0);
    feed(17'd1);
    feed(17'd2);
    feed(17'd3);
    checkEq("clr_next_valid", oVALID, 1);
    checkEq("clr_next_sum", oSUM, 6);
    checkEq("clr_next_max", oMAX, 3);
    stepClk();

    // Push and pop together at occupancy 1
    iREADY = 1'b0;
    iLEN = 4'd2;
    feed(17'd7);
    feed(17'd8);
    checkEq("pp_first_sum", oSUM, 15);
    feed(17'd1);
    iREADY = 1'b1;
    feed(17'd2);
    checkEq("pp_valid", oVALID, 1);
    checkEq("pp_new_head_sum", oSUM, 3);
    checkEq("pp_new_head_max", oMAX, 2);
    checkEq("pp_occ1_ready", oREADY, 1);
    stepClk();
    checkEq("pp_occ_was_1", oVALID, 0);

    // Reset with a full FIFO and a stalled sample
    iREADY = 1'b0;
    iLEN = 4'd1;
    feed(17'd9);
    feed(17'd11);
    checkEq("rf_full", oREADY, 0);
    iVALID = 1'b1;
    iRESULT = 17'd13;
    iRST = 1'b1;
    stepClk();
    iVALID = 1'b0;
    checkEq("rf_ready_in_rst", oREADY, 0);
    iRST = 1'b0;
    #1;
    checkEq("rf_valid", oVALID, 0);
    checkEq("rf_sum", oSUM, 0);
    checkEq("rf_ready", oREADY, 1);

    // Reset mid-frame, next frame starts fresh
    iREADY = 1'b1;
    iLEN = 4'd4;
    feed(17'd1);
    feed(17'd2);
    checkEq("rm_busy_before", oBUSY, 1);
    iRST = 1'b1;
    stepClk();
    iRST = 1'b0;
    #1;
    checkEq("rm_count", oCOUNT, 0);
    checkEq("rm_busy", oBUSY, 0);
    checkEq("rm_ready", oREADY, 1);
    iLEN = 4'd2;
    feed(17'd5);
    feed(17'd6);
    checkEq("rm_valid", oVALID, 1);
    checkEq("rm_sum", oSUM, 11);
    checkEq("rm_max", oMAX, 6);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
